factorial_ctrl: RTL

//  FSM controller for the 16-bit factorial datapath; computes result = n! by repeated multiply.

---
 rtl/factorial_ctrl_pkg.sv | 66 ++++++
 rtl/fact_wait_timer.sv | 36 +++
 rtl/factorial_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/factorial_ctrl_pkg.sv
// Shared definitions for the factorial controller and datapath:
// state encodings, result-mux selects and the registered control-output bundle.
package factorial_ctrl_pkg;

    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned N_W_DEF         = 4;
    localparam int unsigned MAX_N_DEF       = 8;
    localparam int unsigned MUL_TIMEOUT_DEF = 16;
    localparam int unsigned TMR_W_DEF       = 5;

    localparam logic [1:0] SEL_INIT = 2'b00;
    localparam logic [1:0] SEL_PROD = 2'b01;
    localparam logic [1:0] SEL_HOLD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_CHECK    = 3'd2,
        ST_MUL_REQ  = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_LOAD     = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } state_e;

    typedef struct packed {
        logic [1:0] res_sel;
        logic       res_ld;
        logic       mul_start;
        logic       busy;
        logic       done;
        logic       err;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_OUT_RST = '{
        res_sel:   SEL_HOLD,
        res_ld:    1'b0,
        mul_start: 1'b0,
        busy:      1'b0,
        done:      1'b0,
        err:       1'b0
    };

    // Moore output decode for a given state.
    function automatic ctrl_out_t decode_outputs(input state_e s);
        ctrl_out_t o;
        o      = CTRL_OUT_RST;
        o.busy = (s != ST_IDLE);
        case (s)
            ST_INIT: begin
                o.res_sel = SEL_INIT;
                o.res_ld  = 1'b1;
            end
            ST_MUL_REQ: o.mul_start = 1'b1;
            ST_LOAD: begin
                o.res_sel = SEL_PROD;
                o.res_ld  = 1'b1;
            end
            ST_DONE: o.done = 1'b1;
            ST_ERR:  o.err  = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fact_wait_timer.sv
// Multiplier wait timer: cleared on launch, counts while waiting,
// flags the last permitted wait cycle.
module fact_wait_timer #(
    parameter int unsigned TMR_W       = 5,
    parameter int unsigned MUL_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (enable) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign tc_c = (timer_q == TMR_W'(MUL_TIMEOUT - 1));

endmodule

// File: rtl/factorial_ctrl.sv
// Factorial controller: sequences init, multiply and load of the result register,
// hands the loop count to the multiplier, and reports done/err to the host.
module factorial_ctrl
    import factorial_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned N_W         = N_W_DEF,
    parameter int unsigned MAX_N       = MAX_N_DEF,
    parameter int unsigned MUL_TIMEOUT = MUL_TIMEOUT_DEF,
    parameter int unsigned TMR_W       = TMR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_W-1:0]    n_in,
    input  logic              mul_done,
    output logic [1:0]        res_sel,
    output logic              res_ld,
    output logic              mul_start,
    output logic [DATA_W-1:0] operand_o,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e         state_q;
    state_e         state_d;
    logic [N_W-1:0] cnt_q;
    logic [N_W-1:0] cnt_d;
    ctrl_out_t      out_q;
    ctrl_out_t      out_d;
    logic           tmr_clr;
    logic           tmr_en;
    logic           tmr_tc_c;

    fact_wait_timer #(
        .TMR_W       (TMR_W),
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .tc_c   (tmr_tc_c)
    );

    // Next state, loop counter and timer control; outputs are decoded from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (32'(n_in) > MAX_N) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_INIT;
                            cnt_d   = n_in;
                        end
                    end
                end
                ST_INIT: state_d = ST_CHECK;
                ST_CHECK: begin
                    if (cnt_q <= N_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL_REQ;
                    end
                end
                ST_MUL_REQ: begin
                    tmr_clr = 1'b1;
                    state_d = ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (mul_done) begin
                        state_d = ST_LOAD;
                    end else if (tmr_tc_c) begin
                        state_d = ST_ERR;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                // CHECK only routes here with cnt >= 2, so the decrement cannot wrap.
                ST_LOAD: begin
                    cnt_d   = cnt_q - N_W'(1);
                    state_d = ST_CHECK;
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        out_d = decode_outputs(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= CTRL_OUT_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign res_sel   = out_q.res_sel;
    assign res_ld    = out_q.res_ld;
    assign mul_start = out_q.mul_start;
    assign busy      = out_q.busy;
    assign done      = out_q.done;
    assign err       = out_q.err;
    assign operand_o = DATA_W'(cnt_q);

endmodule
